time_counter: RTL
=================

// Module: time_counter
// PURPOSE
//  Timekeeping core of the clock. Counts hh:mm:ss from the system clock and
//  drives data_ch, the current time, to the setup and display blocks.
//  Consumes setup_data/setup_imp from the setup block: a rising edge on
//  setup_imp loads the user-set time. Produces 1-cycle tick pulses for display.
// PARAMETERS
//  CLK_FREQ  50_000_000  clock cycles per second (prescaler terminal count + 1); >= 2
// PORTS
//  clock       in   1   system clock, all logic on posedge
//  reset       in   1   synchronous, active-high
//  setup_data  in   24  time to load: [23:16] hours, [15:8] minutes, [7:0] seconds, binary
//  setup_imp   in   1   load request level; only its rising edge acts
//  rezhim      in   2   current UI mode (1 = setup mode); used only with CLOCK_CORE_HOLD_EN
//  data_ch     out  24  current time, same field layout as setup_data, binary
//  sec_tick    out  1   1-cycle pulse on every seconds increment
//  day_wrap    out  1   1-cycle pulse when 23:59:59 rolls over to 00:00:00
// BEHAVIOUR
//  - Reset: data_ch=0, sec_tick=0, day_wrap=0, prescaler=0, setup_imp_d=0.
//  - Prescaler: counts 0..CLK_FREQ-1 and wraps to 0. Tick fires on the cycle it
//    equals CLK_FREQ-1. Width = $clog2(CLK_FREQ).
//  - On tick: sec+1. sec 59->0 carries to min+1. min 59->0 carries to hr+1.
//    hr 23->0 with min=59, sec=59 asserts day_wrap.
//  - data_ch, sec_tick and day_wrap are registered and update on the same edge
//    as the tick. Upper unused bits of each field stay 0.
//  - Load edge detect: setup_imp_d <= setup_imp; load = setup_imp & ~setup_imp_d.
//    A held-high setup_imp loads once. Re-arms only after setup_imp is seen low.
//  - On load: data_ch <= setup_data, visible the cycle after load is sampled
//    (1-cycle latency). Prescaler <= 0, so the first tick after a load comes
//    CLK_FREQ cycles later.
//  - Range check on load, per field: hours>23, minutes>59 or seconds>59 loads
//    that field as 0. Other fields load normally.
//  - Load and tick in the same cycle: load wins. No increment, sec_tick=0,
//    day_wrap=0.
//  - Reset asserted mid-count or during a load: reset wins in that cycle.
//  - sec_tick/day_wrap are never high for more than 1 cycle. No other outputs.
// CONFIGURATION
//  CLOCK_CORE_HOLD_EN defined: while rezhim==1 the prescaler and time counters
//    freeze (no ticks). Loads still act. On leaving rezhim==1, counting resumes
//    from the frozen prescaler value.
//  CLOCK_CORE_HOLD_EN undefined: rezhim is ignored (port kept, unused) and time
//    counts in every mode.
// TESTING (CLK_FREQ=4 unless noted)
//  1 reset 3 cycles, release -> data_ch=0; sec_tick on cycles 4,8,12 after
//    release; data_ch=0x000003 after 12 cycles.
//  2 load 0x173B3A (23:59:58), run 8 cycles -> 0x173B3B, then 0x000000 with
//    day_wrap=1 for exactly 1 cycle.
//  3 setup_imp held high 10 cycles with setup_data=0x0A0B0C -> single load;
//    data_ch counts on to 0x0A0B0D after 4 more cycles (no reload).
//  4 load 0x18_3C_3C (24:60:60) -> data_ch=0x000000. Load 0x05_3C_10 ->
//    data_ch=0x050010.
//  5 assert load on the tick cycle (prescaler=3) -> data_ch=setup_data,
//    sec_tick=0, next tick 4 cycles later.
//  6 HOLD_EN built: rezhim=1 for 20 cycles -> data_ch unchanged, no sec_tick.
//    rezhim=0 -> ticks resume. Non-HOLD build: same stimulus counts 5 seconds.

Source files
------------

// File: rtl/time_counter.sv
// Timekeeping core: binary hh:mm:ss counter driven by a CLK_FREQ prescaler, with edge-triggered time load.
// Optional macro CLOCK_CORE_HOLD_EN freezes counting while rezhim==1.
module time_counter #(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [23:0] setup_data,
  input  logic        setup_imp,
  input  logic [1:0]  rezhim,
  output logic [23:0] data_ch,
  output logic        sec_tick,
  output logic        day_wrap
);

  localparam int            PW       = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_FREQ - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    hr_q, hr_d, min_q, min_d, sec_q, sec_d;
  logic          sec_tick_q, sec_tick_d;
  logic          day_wrap_q, day_wrap_d;
  logic          setup_imp_q;
  logic          hold, load, tick;

`ifdef CLOCK_CORE_HOLD_EN
  assign hold = (rezhim == 2'd1);
`else
  logic unused_rezhim;
  assign unused_rezhim = ^rezhim;
  assign hold          = 1'b0;
`endif

  assign load = setup_imp & ~setup_imp_q;
  assign tick = ~hold & (presc_q == PRE_LAST);

  always_comb begin
    presc_d    = presc_q;
    hr_d       = hr_q;
    min_d      = min_q;
    sec_d      = sec_q;
    sec_tick_d = 1'b0;
    day_wrap_d = 1'b0;
    if (load) begin
      // Load beats a coincident tick; out-of-range fields are cleared individually.
      presc_d = '0;
      hr_d    = (setup_data[23:16] > 8'd23) ? 8'd0 : setup_data[23:16];
      min_d   = (setup_data[15:8]  > 8'd59) ? 8'd0 : setup_data[15:8];
      sec_d   = (setup_data[7:0]   > 8'd59) ? 8'd0 : setup_data[7:0];
    end else if (tick) begin
      presc_d    = '0;
      sec_tick_d = 1'b1;
      if (sec_q == 8'd59) begin
        sec_d = 8'd0;
        if (min_q == 8'd59) begin
          min_d = 8'd0;
          if (hr_q == 8'd23) begin
            hr_d       = 8'd0;
            day_wrap_d = 1'b1;
          end else begin
            hr_d = hr_q + 8'd1;
          end
        end else begin
          min_d = min_q + 8'd1;
        end
      end else begin
        sec_d = sec_q + 8'd1;
      end
    end else if (!hold) begin
      presc_d = presc_q + PW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      presc_q     <= '0;
      hr_q        <= 8'd0;
      min_q       <= 8'd0;
      sec_q       <= 8'd0;
      sec_tick_q  <= 1'b0;
      day_wrap_q  <= 1'b0;
      setup_imp_q <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      hr_q        <= hr_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      sec_tick_q  <= sec_tick_d;
      day_wrap_q  <= day_wrap_d;
      setup_imp_q <= setup_imp;
    end
  end

  assign data_ch  = {hr_q, min_q, sec_q};
  assign sec_tick = sec_tick_q;
  assign day_wrap = day_wrap_q;

endmodule
